// File: rtl/neo_pkg.sv
// Shared types and field widths for the NeoPixel frame arbiter and its
// round-robin picker.
package neo_pkg;

  localparam int PIX_W  = 3;
  localparam int CIDX_W = 2;
  localparam int LVL_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    SENDING = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [PIX_W-1:0]  pixel_index;
    logic [CIDX_W-1:0] color_index;
    logic [LVL_W-1:0]  color_level;
  } neo_load_t;

endpackage

// File: rtl/neo_frame_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching from
// (last+1) mod N, wrapping, so the previous owner is checked last.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            valid,
  output logic [ID_W-1:0] winner,
  output logic [N-1:0]    onehot
);

  int idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner      = ID_W'(idx);
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/neo_frame_arbiter.sv
// Grants the shared NeoPixel load/send controller to one producer per frame.
// state   | meaning
// IDLE    | no owner; pick next requester round-robin
// OWNED   | owner's loads/send muxed to driver; watchdog running
// SENDING | send accepted; wait for driver done_wait
// RELEASE | one-cycle gap with grant low; remember last owner
module neo_frame_arbiter
  import neo_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024,
  parameter int ID_W    = $clog2(N),
  parameter int WD_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        req_load_color,
  input  logic [N*PIX_W-1:0]  req_pixel_index,
  input  logic [N*CIDX_W-1:0] req_color_index,
  input  logic [N*LVL_W-1:0]  req_color_level,
  input  logic [N-1:0]        req_send_it,
  input  logic                ready_to_load,
  input  logic                ready_to_send,
  input  logic                done_wait,
  output logic [N-1:0]        grant,
  output logic [N-1:0]        grant_ready_to_load,
  output logic [N-1:0]        grant_ready_to_send,
  output logic                load_color,
  output logic [PIX_W-1:0]    pixel_index,
  output logic [CIDX_W-1:0]   color_index,
  output logic [LVL_W-1:0]    color_level,
  output logic                send_it,
  output logic [ID_W-1:0]     owner_id,
  output logic                busy,
  output logic [15:0]         frame_count,
  output logic                timeout_pulse
);

  arb_state_t      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [N-1:0]    pick_onehot;

  logic            own_req, own_load, own_send;
  neo_load_t       own_fields, drv_fields;

  rr_pick #(.N(N), .ID_W(ID_W)) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_id),
    .onehot (pick_onehot)
  );

  assign own_req                 = req[owner_q];
  assign own_load                = req_load_color[owner_q];
  assign own_send                = req_send_it[owner_q];
  assign own_fields.pixel_index  = req_pixel_index[PIX_W*int'(owner_q) +: PIX_W];
  assign own_fields.color_index  = req_color_index[CIDX_W*int'(owner_q) +: CIDX_W];
  assign own_fields.color_level  = req_color_level[LVL_W*int'(owner_q) +: LVL_W];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
    wd_d        = wd_q;
    timeout_d   = 1'b0;
    load_color  = 1'b0;
    send_it     = 1'b0;
    drv_fields  = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          owner_d = pick_id;
          wd_d    = '0;
          state_d = OWNED;
        end
      end

      OWNED: begin
        // Send has priority; a coincident load is dropped.
        send_it    = own_send & ready_to_send;
        load_color = own_load & ready_to_load & ~send_it;
        if (load_color) drv_fields = own_fields;

        if (load_color || send_it) wd_d = '0;
        else if (wd_q != WD_W'(TIMEOUT)) wd_d = wd_q + 1'b1;

        if (send_it) begin
          state_d = SENDING;
        end else if (!own_req) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (!load_color && (wd_q == WD_W'(TIMEOUT - 1))) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end
      end

      SENDING: begin
        if (done_wait) begin
          grant_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = RELEASE;
        end
      end

      RELEASE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      last_q      <= ID_W'(N - 1);
      frame_cnt_q <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant               = grant_q;
  assign grant_ready_to_load = {N{ready_to_load}} & grant_q;
  assign grant_ready_to_send = {N{ready_to_send}} & grant_q;
  assign pixel_index         = drv_fields.pixel_index;
  assign color_index         = drv_fields.color_index;
  assign color_level         = drv_fields.color_level;
  assign owner_id            = owner_q;
  assign busy                = (state_q != IDLE);
  assign frame_count         = frame_cnt_q;
  assign timeout_pulse       = timeout_q;

endmodule

// File: tb/tb_neo_frame_arbiter.sv
// Directed bench for neo_frame_arbiter (N=4, TIMEOUT=1024): frame handshake,
// rotation, send/load priority, abandon, watchdog, async reset and wrap.
module tb_neo_frame_arbiter;
  import neo_pkg::*;

  localparam int N  = 4;
  localparam int ID = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_load_color, req_send_it;
  logic [N*3-1:0] req_pixel_index;
  logic [N*2-1:0] req_color_index;
  logic [N*8-1:0] req_color_level;
  logic          ready_to_load, ready_to_send, done_wait;
  logic [N-1:0]  grant, grant_ready_to_load, grant_ready_to_send;
  logic          load_color, send_it, busy, timeout_pulse;
  logic [2:0]    pixel_index;
  logic [1:0]    color_index;
  logic [7:0]    color_level;
  logic [ID-1:0] owner_id;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  neo_frame_arbiter #(.N(N), .TIMEOUT(1024)) dut (
    .clock               (clock),
    .reset               (reset),
    .req                 (req),
    .req_load_color      (req_load_color),
    .req_pixel_index     (req_pixel_index),
    .req_color_index     (req_color_index),
    .req_color_level     (req_color_level),
    .req_send_it         (req_send_it),
    .ready_to_load       (ready_to_load),
    .ready_to_send       (ready_to_send),
    .done_wait           (done_wait),
    .grant               (grant),
    .grant_ready_to_load (grant_ready_to_load),
    .grant_ready_to_send (grant_ready_to_send),
    .load_color          (load_color),
    .pixel_index         (pixel_index),
    .color_index         (color_index),
    .color_level         (color_level),
    .send_it             (send_it),
    .owner_id            (owner_id),
    .busy                (busy),
    .frame_count         (frame_count),
    .timeout_pulse       (timeout_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req             = '0;
    req_load_color  = '0;
    req_send_it     = '0;
    req_pixel_index = '0;
    req_color_index = '0;
    req_color_level = '0;
    ready_to_load   = 1'b0;
    ready_to_send   = 1'b0;
    done_wait       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int got_n, gap, n;
    logic [N-1:0] prev;

    // Reset state
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_to", timeout_pulse, 0);
    chk("rst_send", send_it, 0);
    @(negedge clock);
    reset = 1'b0;

    // Single producer: 3 loads, non-owner strobe, send, done
    req = 4'b0001;
    #1 chk("lat_grant0", grant, 0);
    @(negedge clock);
    #1;
    chk("t1_grant", grant, 4'b0001);
    chk("t1_owner", owner_id, 0);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      ready_to_load          = 1'b1;
      req_load_color         = 4'b0001;
      req_pixel_index[2:0]   = 3'(i + 1);
      req_color_index[1:0]   = 2'(i);
      req_color_level[7:0]   = 8'hA0 + 8'(i);
      #1;
      chk("t1_load", load_color, 1);
      chk("t1_pix", pixel_index, i + 1);
      chk("t1_cidx", color_index, i);
      chk("t1_lvl", color_level, 32'hA0 + i);
      chk("t1_grl", grant_ready_to_load, 4'b0001);
      @(negedge clock);
    end
    req_load_color       = 4'b0010;
    req_pixel_index[5:3] = 3'd7;
    done_wait            = 1'b1;
    #1;
    chk("t1_nonown_load", load_color, 0);
    chk("t1_nonown_pix", pixel_index, 0);
    @(negedge clock);
    done_wait      = 1'b0;
    req_load_color = '0;
    req_send_it    = 4'b0001;
    ready_to_send  = 1'b1;
    #1;
    chk("t1_grant_hold", grant, 4'b0001);
    chk("t1_send", send_it, 1);
    chk("t1_send_noload", load_color, 0);
    @(negedge clock);
    req = '0;
    #1;
    chk("t1_sending_out", send_it, 0);
    chk("t1_sending_grant", grant, 4'b0001);
    req_send_it = '0;
    done_wait   = 1'b1;
    @(negedge clock);
    done_wait = 1'b0;
    #1;
    chk("t1_rel_grant", grant, 0);
    chk("t1_fc", frame_count, 1);
    @(negedge clock);
    #1 chk("t1_idle_busy", busy, 0);

    // All producers, immediate send: strict rotation with gaps
    do_reset();
    req           = 4'b1111;
    req_send_it   = 4'b1111;
    ready_to_send = 1'b1;
    done_wait     = 1'b1;
    got_n = 0;
    gap   = 0;
    prev  = '0;
    for (int c = 0; c < 60 && got_n < 5; c++) begin
      @(negedge clock);
      #1;
      if (grant != 0) begin
        if (prev == 0) begin
          if (got_n > 0) chk("rot_gap", 32'(gap >= 2), 1);
          chk("rot_order", grant, 32'(1) << (got_n % N));
          got_n++;
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev = grant;
    end
    chk("rot_count", got_n, 5);
    chk("rot_fc", frame_count, 4);

    // Owner 2: load and send together -> send wins
    do_reset();
    req = 4'b0100;
    @(negedge clock);
    #1 chk("t3_grant", grant, 4'b0100);
    req_load_color        = 4'b0100;
    req_send_it           = 4'b0100;
    req_pixel_index[8:6]  = 3'd5;
    req_color_level[23:16] = 8'h3C;
    ready_to_load         = 1'b1;
    ready_to_send         = 1'b1;
    #1;
    chk("t3_send", send_it, 1);
    chk("t3_load_supp", load_color, 0);
    chk("t3_pix_zero", pixel_index, 0);
    @(negedge clock);
    #1;
    chk("t3_sending_send", send_it, 0);
    chk("t3_sending_load", load_color, 0);
    chk("t3_sending_grant", grant, 4'b0100);
    clear_inputs();
    done_wait = 1'b1;
    @(negedge clock);
    done_wait = 1'b0;
    #1 chk("t3_fc", frame_count, 1);

    // Owner 1 abandons; producer 2 next
    do_reset();
    req = 4'b0010;
    @(negedge clock);
    #1;
    chk("t4_grant", grant, 4'b0010);
    chk("t4_owner", owner_id, 1);
    req_load_color = 4'b0010;
    ready_to_load  = 1'b1;
    #1 chk("t4_load", load_color, 1);
    @(negedge clock);
    req_load_color = '0;
    req            = 4'b0100;
    @(negedge clock);
    #1;
    chk("t4_rel_grant", grant, 0);
    chk("t4_fc", frame_count, 0);
    chk("t4_owner_keep", owner_id, 1);
    @(negedge clock);
    #1 chk("t4_idle_grant", grant, 0);
    @(negedge clock);
    #1;
    chk("t4_next_grant", grant, 4'b0100);
    chk("t4_next_owner", owner_id, 2);

    // Watchdog: owner 2 stays idle
    n = 0;
    while (n < 1100) begin
      @(negedge clock);
      n++;
      #1;
      if (timeout_pulse) break;
    end
    chk("wd_cycle", n, 1024);
    chk("wd_grant", grant, 0);
    chk("wd_fc", frame_count, 0);
    @(negedge clock);
    #1 chk("wd_pulse_once", timeout_pulse, 0);
    req = '0;

    // Async reset in SENDING
    @(negedge clock);
    req = 4'b0001;
    @(negedge clock);
    #1 chk("t6_grant", grant, 4'b0001);
    req_send_it   = 4'b0001;
    ready_to_send = 1'b1;
    @(negedge clock);
    req           = 4'b1001;
    req_send_it   = '0;
    ready_to_load = 1'b1;
    #1 chk("t6_grs", grant_ready_to_send, 4'b0001);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_send", send_it, 0);
    chk("t6_rst_grl", grant_ready_to_load, 0);
    chk("t6_rst_fc", frame_count, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1 chk("t6_first_grant", grant, 4'b0001);

    // Frame counter wrap
    req           = '0;
    ready_to_load = 1'b0;
    ready_to_send = 1'b0;
    repeat (2) @(negedge clock);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_cnt_q;
    #1 chk("wrap_preload", frame_count, 16'hFFFF);
    req = 4'b0001;
    @(negedge clock);
    req_send_it   = 4'b0001;
    ready_to_send = 1'b1;
    @(negedge clock);
    clear_inputs();
    done_wait = 1'b1;
    @(negedge clock);
    done_wait = 1'b0;
    #1 chk("wrap_fc", frame_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
